// File: rtl/dp_pkg.sv
// Shared types for the pipelined datapath: op encodings, the control
// descriptor carried down the pipe, and status register bit positions.
package dp_pkg;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_AND  = 2'b10,
    ALU_NOTB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    VSEL_ALU   = 2'b00,
    VSEL_PC    = 2'b01,
    VSEL_IMM8  = 2'b10,
    VSEL_MDATA = 2'b11
  } vsel_e;

  typedef struct packed {
    logic    write;
    vsel_e   vsel;
    logic    asel;
    logic    bsel;
    shift_e  shift;
    alu_op_e alu_op;
    logic    loads;
  } ctrl_t;

  localparam int ST_W = 3;
  localparam int ST_N = 2;
  localparam int ST_V = 1;
  localparam int ST_Z = 0;

endpackage

// File: rtl/dp_regfile.sv
// NREG x WIDTH register file: two combinational read ports, one synchronous
// write port, asynchronous clear. A same-cycle read of a written register sees the old value.
module dp_regfile #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  localparam int RW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [RW-1:0]    i_wnum,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [RW-1:0]    i_rnum_a,
  input  logic [RW-1:0]    i_rnum_b,
  output logic [WIDTH-1:0] o_rdata_a,
  output logic [WIDTH-1:0] o_rdata_b
);

  logic [WIDTH-1:0] r_mem [NREG];

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_wnum] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_rnum_a];
  assign o_rdata_b = r_mem[i_rnum_b];

endmodule

// File: rtl/pipe_datapath.sv
// Three-stage (RD / EX / WB) datapath with NVZ status and RAW hazard handling.
// Define DP_FWD_EN to forward from EX/WB instead of stalling on hazards.
module pipe_datapath
  import dp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int PC_W  = 8,
  localparam int RW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RW-1:0]    writenum,
  input  logic             write,
  input  logic [RW-1:0]    readnum_a,
  input  logic [RW-1:0]    readnum_b,
  input  logic [1:0]       vsel,
  input  logic             asel,
  input  logic             bsel,
  input  logic [1:0]       shift,
  input  logic [1:0]       ALUop,
  input  logic             loads,
  input  logic [WIDTH-1:0] sximm8,
  input  logic [WIDTH-1:0] sximm5,
  input  logic [WIDTH-1:0] mdata,
  input  logic [PC_W-1:0]  PC,
  output logic             out_valid,
  output logic [WIDTH-1:0] datapath_out,
  output logic             N,
  output logic             V,
  output logic             Z
);

  // Handshake: a descriptor moves into the pipe on a rising edge where
  // in_valid && in_ready; it must stay stable while in_valid && !in_ready.

  function automatic logic [WIDTH-1:0] wb_sel(input vsel_e s, input logic [WIDTH-1:0] alu,
                                              input logic [PC_W-1:0] pc,
                                              input logic [WIDTH-1:0] imm8,
                                              input logic [WIDTH-1:0] md);
    case (s)
      VSEL_ALU:  return alu;
      VSEL_PC:   return WIDTH'(pc);
      VSEL_IMM8: return imm8;
      default:   return md;
    endcase
  endfunction

  ctrl_t            w_in_ctrl;
  logic             w_accept, w_stall;
  logic [WIDTH-1:0] w_rf_a, w_rf_b, w_opnd_a, w_opnd_b;

  logic             r_ex_valid;
  ctrl_t            r_ex_ctrl;
  logic [RW-1:0]    r_ex_wnum;
  logic [WIDTH-1:0] r_a, r_b, r_ex_sximm8, r_ex_sximm5, r_ex_mdata;
  logic [PC_W-1:0]  r_ex_pc;

  logic             r_wb_valid, r_wb_write;
  logic [RW-1:0]    r_wb_wnum;
  vsel_e            r_wb_vsel;
  logic [WIDTH-1:0] r_c, r_wb_sximm8, r_wb_mdata;
  logic [PC_W-1:0]  r_wb_pc;
  logic [ST_W-1:0]  r_status;

  logic [WIDTH-1:0] w_b_shift, w_ain, w_bin, w_alu, w_wb_data;
  logic             w_ovf;
  logic [ST_W-1:0]  w_status_next;

  assign w_in_ctrl = '{write: write, vsel: vsel_e'(vsel), asel: asel, bsel: bsel,
                       shift: shift_e'(shift), alu_op: alu_op_e'(ALUop), loads: loads};

  // Only operands actually consumed by the incoming op can create a hazard.
  logic w_ex_wr, w_wb_wr, w_ex_hit_a, w_ex_hit_b, w_wb_hit_a, w_wb_hit_b;
  assign w_ex_wr    = r_ex_valid && r_ex_ctrl.write;
  assign w_wb_wr    = r_wb_valid && r_wb_write;
  assign w_ex_hit_a = w_ex_wr && !asel && (r_ex_wnum == readnum_a);
  assign w_ex_hit_b = w_ex_wr && !bsel && (r_ex_wnum == readnum_b);
  assign w_wb_hit_a = w_wb_wr && !asel && (r_wb_wnum == readnum_a);
  assign w_wb_hit_b = w_wb_wr && !bsel && (r_wb_wnum == readnum_b);

  dp_regfile #(.WIDTH(WIDTH), .NREG(NREG)) u_regfile (
    .clk       (clk),
    .i_rst     (reset),
    .i_we      (w_wb_wr),
    .i_wnum    (r_wb_wnum),
    .i_wdata   (w_wb_data),
    .i_rnum_a  (readnum_a),
    .i_rnum_b  (readnum_b),
    .o_rdata_a (w_rf_a),
    .o_rdata_b (w_rf_b)
  );

`ifdef DP_FWD_EN
  logic [WIDTH-1:0] w_ex_data;
  assign w_ex_data = wb_sel(r_ex_ctrl.vsel, w_alu, r_ex_pc, r_ex_sximm8, r_ex_mdata);
  assign w_stall   = 1'b0;
  // The younger producer (EX) wins over WB.
  assign w_opnd_a  = w_ex_hit_a ? w_ex_data : (w_wb_hit_a ? w_wb_data : w_rf_a);
  assign w_opnd_b  = w_ex_hit_b ? w_ex_data : (w_wb_hit_b ? w_wb_data : w_rf_b);
`else
  assign w_stall  = in_valid && (w_ex_hit_a || w_ex_hit_b || w_wb_hit_a || w_wb_hit_b);
  assign w_opnd_a = w_rf_a;
  assign w_opnd_b = w_rf_b;
`endif

  assign in_ready = !reset && !w_stall;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    case (r_ex_ctrl.shift)
      SH_LSL1: w_b_shift = {r_b[WIDTH-2:0], 1'b0};
      SH_LSR1: w_b_shift = {1'b0, r_b[WIDTH-1:1]};
      SH_ASR1: w_b_shift = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
      default: w_b_shift = r_b;
    endcase
    w_ain = r_ex_ctrl.asel ? '0 : r_a;
    w_bin = r_ex_ctrl.bsel ? r_ex_sximm5 : w_b_shift;
  end

  always_comb begin
    w_alu = '0;
    w_ovf = 1'b0;
    case (r_ex_ctrl.alu_op)
      ALU_ADD: begin
        w_alu = w_ain + w_bin;
        w_ovf = (w_ain[WIDTH-1] == w_bin[WIDTH-1]) && (w_alu[WIDTH-1] != w_ain[WIDTH-1]);
      end
      ALU_SUB: begin
        w_alu = w_ain - w_bin;
        w_ovf = (w_ain[WIDTH-1] != w_bin[WIDTH-1]) && (w_alu[WIDTH-1] != w_ain[WIDTH-1]);
      end
      ALU_AND:  w_alu = w_ain & w_bin;
      default:  w_alu = ~w_bin;
    endcase
    w_status_next       = '0;
    w_status_next[ST_N] = w_alu[WIDTH-1];
    w_status_next[ST_V] = w_ovf;
    w_status_next[ST_Z] = (w_alu == '0);
  end

  assign w_wb_data = wb_sel(r_wb_vsel, r_c, r_wb_pc, r_wb_sximm8, r_wb_mdata);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_valid  <= 1'b0;
      r_ex_ctrl   <= '0;
      r_ex_wnum   <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_ex_sximm8 <= '0;
      r_ex_sximm5 <= '0;
      r_ex_mdata  <= '0;
      r_ex_pc     <= '0;
    end else begin
      r_ex_valid <= w_accept;
      if (w_accept) begin
        r_ex_ctrl   <= w_in_ctrl;
        r_ex_wnum   <= writenum;
        r_a         <= w_opnd_a;
        r_b         <= w_opnd_b;
        r_ex_sximm8 <= sximm8;
        r_ex_sximm5 <= sximm5;
        r_ex_mdata  <= mdata;
        r_ex_pc     <= PC;
      end
    end
  end

  // Bubbles in EX leave C and status untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_valid  <= 1'b0;
      r_wb_write  <= 1'b0;
      r_wb_wnum   <= '0;
      r_wb_vsel   <= VSEL_ALU;
      r_c         <= '0;
      r_wb_sximm8 <= '0;
      r_wb_mdata  <= '0;
      r_wb_pc     <= '0;
      r_status    <= '0;
    end else begin
      r_wb_valid <= r_ex_valid;
      if (r_ex_valid) begin
        r_c         <= w_alu;
        r_wb_write  <= r_ex_ctrl.write;
        r_wb_wnum   <= r_ex_wnum;
        r_wb_vsel   <= r_ex_ctrl.vsel;
        r_wb_sximm8 <= r_ex_sximm8;
        r_wb_mdata  <= r_ex_mdata;
        r_wb_pc     <= r_ex_pc;
        if (r_ex_ctrl.loads) r_status <= w_status_next;
      end
    end
  end

  assign out_valid    = r_wb_valid;
  assign datapath_out = r_c;
  assign N            = r_status[ST_N];
  assign V            = r_status[ST_V];
  assign Z            = r_status[ST_Z];

endmodule
